// File: rtl/debounce_pkg.sv
// ============================================================================
// debounce_pkg : shared constants and the counter-width helper for input_debouncer
// Rev 1.0
// ============================================================================
`default_nettype none

package debounce_pkg;

    localparam int DEFAULT_NUM_CH          = 3;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Channel order as the gate stage consumes the debounced levels
    localparam int CH_A  = 0;
    localparam int CH_B  = 1;
    localparam int CH_F1 = 2;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// debounce_channel : synchronizer, stability filter and edge pulses for one pin
// Edge pulses exist only when DEBOUNCE_EDGE_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic [CNT_W-1:0]       cnt;
    logic                   stable;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    // Any agreement between sync and stable discards the partial run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt    <= '0;
            stable <= sync;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stable_o = stable;

`ifdef DEBOUNCE_EDGE_EN
    logic stable_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_prev <= 1'b0;
        end else begin
            stable_prev <= stable;
        end
    end

    assign rise_o = stable & ~stable_prev;
    assign fall_o = ~stable & stable_prev;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================================
// input_debouncer : NUM_CH independent debounce channels feeding the gate stage
// Optional edge pulses via DEBOUNCE_EDGE_EN. Rev 1.0
// ============================================================================
`default_nettype none

module input_debouncer
    import debounce_pkg::*;
#(
    parameter int NUM_CH          = DEFAULT_NUM_CH,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] raw_i,
    output logic [NUM_CH-1:0] stable_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_channel (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .raw_i    (raw_i[ch]),
            .stable_o (stable_o[ch]),
            .rise_o   (rise_o[ch]),
            .fall_o   (fall_o[ch])
        );
    end

endmodule

`default_nettype wire

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
Conditions raw asynchronous switch/pin inputs before they reach the logic gate stage (enable, inverter, and, or, xor gates).
Per channel, the block provides:
- a synchronizer
- a consecutive-cycle stability filter
- optional one-cycle edge pulses
The default channel mapping into the gate stage is stable_o[0] = a, stable_o[1] = b, stable_o[2] = f1.

Parameters:
NUM_CH, 3, number of independent input channels (>=1)
SYNC_STAGES, 2, flip-flop depth of the input synchronizer (>=2)
DEBOUNCE_CYCLES, 4, consecutive synced cycles of disagreement needed to accept a new level (>=1)

Ports:
clk_i  input  1  system clock, all state updates on rising edge
rst_ni  input  1  asynchronous active-low reset
raw_i  input  NUM_CH  unsynchronized raw inputs
stable_o  output  NUM_CH  debounced level per channel, registered
rise_o  output  NUM_CH  one-cycle pulse on a 0->1 change of stable_o
fall_o  output  NUM_CH  one-cycle pulse on a 1->0 change of stable_o

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - all synchronizer flops, counters, stable_o, rise_o and fall_o go to 0 immediately.
  - Reset mid-count discards progress; after release every channel restarts from stable=0, cnt=0.
- Synchronizer: raw_i[n] passes through SYNC_STAGES flops. sync[n] is the last stage.
- Counter per channel: width CNT_W = $clog2(DEBOUNCE_CYCLES+1).
- Filter, evaluated at each rising edge, per channel:
  - sync == stable_o: cnt <= 0 and stable_o holds.
  - sync != stable_o and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync != stable_o and cnt == DEBOUNCE_CYCLES-1: stable_o <= sync and cnt <= 0.
- Latency: a clean raw level change becomes visible on stable_o exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it. Defaults: 6 edges.
- Glitch rejection: any sync disagreement lasting fewer than DEBOUNCE_CYCLES consecutive edges leaves stable_o unchanged and returns cnt to 0.
- DEBOUNCE_CYCLES=1: stable_o follows sync with one extra register delay.
- Edge pulses:
  - rise_o[n]=1 for exactly the one cycle in which stable_o[n] first shows 1 after being 0. fall_o is the same for 0 after 1.
  - rise_o and fall_o of one channel are never both 1.
  - Channels are fully independent; simultaneous changes on several channels produce simultaneous pulses.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.

Optional Feature:
Macro DEBOUNCE_EDGE_EN.
- Defined: rise_o/fall_o are generated as described, from a registered copy of the previous stable_o.
- Undefined: the rise_o/fall_o ports remain in the port list, tied to 0. The previous-state register is not instantiated.

Decomposition:
- Shared package debounce_pkg holds:
  - default constants DEFAULT_NUM_CH=3, DEFAULT_SYNC_STAGES=2, DEFAULT_DEBOUNCE_CYCLES=4
  - the CNT_W computation as a localparam function
  - channel index constants CH_A=0, CH_B=1, CH_F1=2
- Sub-module debounce_channel holds one synchronizer, counter, stable flop and edge logic. It is instantiated NUM_CH times in a generate loop by input_debouncer.

Test Plan:
1. Reset: hold rst_ni=0 with raw_i=3'b111 -> stable_o=000, rise_o=000, fall_o=000. Release; raw_i remains 111 -> stable_o=111 on the 6th edge after release; rise_o=111 for that one cycle only.
2. Clean step: raw_i[0] goes 0->1 and holds -> stable_o[0]=1 exactly 6 edges later; rise_o[0] pulses 1 cycle; other channels stay 0.
3. Glitch: raw_i[1]=1 for 3 clock cycles then 0 -> stable_o[1] stays 0; rise_o[1] never asserts.
4. Bounce: raw_i[2] toggles 1,0,1,0 on successive cycles, then holds 1 -> stable_o[2] rises exactly 6 edges after the final 0->1 step; a single rise_o[2] pulse.
5. Fall and simultaneity: from stable_o=111, drive raw_i=000 at once -> stable_o=000 after 6 edges; fall_o=111 for one cycle; rise_o=000.
6. Reset mid-count: raw_i[0]=1, assert rst_ni=0 after 4 edges, release -> stable_o[0]=0 throughout reset. With raw_i[0] still 1, stable_o[0] rises a full 6 edges after release. With the macro undefined, rise_o/fall_o stay 0 throughout.
